// File: rtl/acc_serializer_if.sv
// Upstream handshake bundle for acc_serializer: active-low data valid,
// address/byte pair, and the ready-for-data response.
interface acc_serializer_if;
  logic       dav_;
  logic [3:0] a3_a0;
  logic [7:0] z7_z0;
  logic       rfd;

  modport master (output dav_, output a3_a0, output z7_z0, input rfd);
  modport slave  (input dav_, input a3_a0, input z7_z0, output rfd);
endinterface

// File: rtl/acc_serializer.sv
// 16 x 8-bit per-address accumulator; each update is sent as a 10-bit async frame.
// Optional macro ACC_SATURATE_EN: accumulators clamp at 8'hFF instead of wrapping.
module acc_serializer #(
  parameter int BIT_CYCLES = 1
) (
  input  logic             clock,
  input  logic             reset_,
  acc_serializer_if.slave  bus,
  output logic             out,
  output logic [7:0]       sum_out
);

  typedef enum logic [2:0] {S0, S1, S2, S3, S4} state_t;

  localparam logic [3:0] TICK_INIT = 4'(BIT_CYCLES);

  logic [7:0] r_mem [16];
  logic [3:0] r_a;
  logic [7:0] r_z;
  logic [7:0] r_last;
  logic [9:0] r_shift;
  logic [3:0] r_bits;
  logic [3:0] r_tick;
  logic       r_rfd;
  state_t     r_star;
  logic [7:0] w_sum;

  function automatic logic [7:0] acc_sum(input logic [7:0] a, input logic [7:0] b);
`ifdef ACC_SATURATE_EN
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8] ? 8'hFF : s[7:0];
`else
    return a + b;
`endif
  endfunction

  always_comb begin
    w_sum = acc_sum(r_mem[r_a], r_z);
  end

  assign out     = r_shift[0];
  assign bus.rfd = r_rfd;
  assign sum_out = r_last;

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      r_star  <= S0;
      r_rfd   <= 1'b1;
      r_shift <= 10'h3FF;
      r_last  <= 8'h00;
      r_a     <= 4'h0;
      r_z     <= 8'h00;
      r_bits  <= 4'h0;
      r_tick  <= 4'h0;
      for (int i = 0; i < 16; i++) r_mem[i] <= 8'h00;
    end else begin
      case (r_star)
        S0: begin
          if (!bus.dav_) begin
            r_a    <= bus.a3_a0;
            r_z    <= bus.z7_z0;
            r_rfd  <= 1'b0;
            r_star <= S1;
          end
        end
        S1: begin
          r_mem[r_a] <= w_sum;
          r_last     <= w_sum;
          r_star     <= S2;
        end
        S2: begin
          // Frame = stop(1), data MSB..LSB, start(0); shifts out from bit 0.
          r_shift <= {1'b1, r_last, 1'b0};
          r_bits  <= 4'd10;
          r_tick  <= TICK_INIT;
          r_star  <= S3;
        end
        S3: begin
          if (r_tick == 4'd1) begin
            r_shift <= {1'b1, r_shift[9:1]};
            r_tick  <= TICK_INIT;
            r_bits  <= r_bits - 4'd1;
            if (r_bits == 4'd1) r_star <= S4;
          end else begin
            r_tick <= r_tick - 4'd1;
          end
        end
        S4: begin
          // Upstream must drop its request before the next pair is taken.
          if (bus.dav_) begin
            r_rfd  <= 1'b1;
            r_star <= S0;
          end
        end
        default: r_star <= S0;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_serializer.sv
// Scoreboard bench for acc_serializer: two instances (1 and 3 clocks per bit).
module tb_acc_serializer;

  logic       clock;
  logic       reset_;
  logic       out1, out3;
  logic [7:0] sum1, sum3;

  acc_serializer_if if1 ();
  acc_serializer_if if3 ();

  acc_serializer #(.BIT_CYCLES(1)) u_b1 (
    .clock(clock), .reset_(reset_), .bus(if1), .out(out1), .sum_out(sum1));
  acc_serializer #(.BIT_CYCLES(3)) u_b3 (
    .clock(clock), .reset_(reset_), .bus(if3), .out(out3), .sum_out(sum3));

  typedef struct {
    int         d;
    int         k;
    logic [7:0] sum;
    bit         abort;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   last_k   = 0;

`ifdef ACC_SATURATE_EN
  localparam logic [7:0] OVF_EXP = 8'hFF;
`else
  localparam logic [7:0] OVF_EXP = 8'h2C;
`endif

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: act=running req=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: act=%0h req=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic f_rfd(input int d);
    return (d == 0) ? if1.rfd : if3.rfd;
  endfunction

  function automatic logic f_out(input int d);
    return (d == 0) ? out1 : out3;
  endfunction

  function automatic logic [7:0] f_sum(input int d);
    return (d == 0) ? sum1 : sum3;
  endfunction

  task automatic drive(input int d, input logic dv, input logic [3:0] a, input logic [7:0] z);
    if (d == 0) begin
      if1.dav_ = dv; if1.a3_a0 = a; if1.z7_z0 = z;
    end else begin
      if3.dav_ = dv; if3.a3_a0 = a; if3.z7_z0 = z;
    end
  endtask

  task automatic start_pair(input int d, input logic [3:0] a, input logic [7:0] z,
                            input logic [7:0] exp_sum, input bit abort);
    int n;
    @(negedge clock);
    drive(d, 1'b0, a, z);
    last_k = cyc + 1;
    q.push_back('{d: d, k: last_k, sum: exp_sum, abort: abort});
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (f_rfd(d) && n < 8);
    if (f_rfd(d)) check("rfd_fall_timeout", 32'(f_rfd(d)), 32'd0);
  endtask

  task automatic finish_pair(input int d, output int rise);
    int n;
    @(negedge clock);
    drive(d, 1'b1, 4'h0, 8'h00);
    n = 0;
    while (!f_rfd(d) && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!f_rfd(d)) check("rfd_rise_timeout", 32'(f_rfd(d)), 32'd1);
    rise = cyc;
  endtask

  task automatic send(input int d, input logic [3:0] a, input logic [7:0] z,
                      input logic [7:0] exp_sum);
    int rise;
    start_pair(d, a, z, exp_sum, 1'b0);
    finish_pair(d, rise);
  endtask

  // Monitor: frames are checked against the scoreboard as the DUT presents them.
  task automatic handle(input int d);
    exp_t       e;
    logic [9:0] frame;
    int         bc;
    if (q.size() == 0) begin
      check("unexpected_frame", 32'(d), 32'hFFFF_FFFF);
      return;
    end
    e = q.pop_front();
    bc = (e.d == 0) ? 1 : 3;
    check("frame_dut", 32'(d), 32'(e.d));
    check("rfd_fall_edge", 32'(cyc), 32'(e.k));
    @(posedge clock); #1;
    check("sum_out", 32'(f_sum(d)), 32'(e.sum));
    if (e.abort) return;
    frame = {1'b1, e.sum, 1'b0};
    for (int j = 0; j < 10; j++) begin
      for (int t = 0; t < bc; t++) begin
        @(posedge clock); #1;
        check($sformatf("out_bit%0d_d%0d", j, d), 32'(f_out(d)), 32'(frame[j]));
      end
    end
    @(posedge clock); #1;
    check("out_idle_s4", 32'(f_out(d)), 32'd1);
  endtask

  initial begin
    logic prev1, prev3;
    prev1 = 1'b1;
    prev3 = 1'b1;
    forever begin
      @(posedge clock); #1;
      if (prev1 && !if1.rfd) handle(0);
      else if (prev3 && !if3.rfd) handle(1);
      prev1 = if1.rfd;
      prev3 = if3.rfd;
    end
  end

  initial begin
    int rise;
    int bad_rfd, bad_sum;
    reset_ = 1'b0;
    drive(0, 1'b1, 4'h0, 8'h00);
    drive(1, 1'b1, 4'h0, 8'h00);
    repeat (3) @(negedge clock);
    check("rst_out_b1", 32'(out1), 32'd1);
    check("rst_rfd_b1", 32'(if1.rfd), 32'd1);
    check("rst_sum_b1", 32'(sum1), 32'd0);
    check("rst_out_b3", 32'(out3), 32'd1);
    check("rst_rfd_b3", 32'(if3.rfd), 32'd1);
    reset_ = 1'b1;
    repeat (2) @(negedge clock);

    // Single pair, minimum handshake cycle of 14 clocks.
    start_pair(0, 4'd5, 8'h3C, 8'h3C, 1'b0);
    finish_pair(0, rise);
    check("rfd_rise_b1", 32'(rise - last_k), 32'd13);

    // Accumulation on address 2, address 3 untouched.
    send(0, 4'd2, 8'h10, 8'h10);
    send(0, 4'd2, 8'h20, 8'h30);
    send(0, 4'd2, 8'h05, 8'h35);
    send(0, 4'd3, 8'h00, 8'h00);

    // Overflow on address 7: 200 + 100.
    send(0, 4'd7, 8'd200, 8'hC8);
    send(0, 4'd7, 8'd100, OVF_EXP);

    // Handshake hold: dav_ kept low for 30 clocks after the frame.
    start_pair(0, 4'd5, 8'h01, 8'h3D, 1'b0);
    while (cyc < last_k + 12) @(negedge clock);
    bad_rfd = 0;
    bad_sum = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (if1.rfd !== 1'b0) bad_rfd++;
      if (sum1 !== 8'h3D) bad_sum++;
    end
    check("hold_rfd_low", 32'(bad_rfd), 32'd0);
    check("hold_sum_stable", 32'(bad_sum), 32'd0);
    drive(0, 1'b1, 4'h0, 8'h00);
    @(posedge clock); #1;
    check("hold_rfd_rise", 32'(if1.rfd), 32'd1);
    send(0, 4'd5, 8'h00, 8'h3D);

    // Bit timing with 3 clocks per bit.
    start_pair(1, 4'd0, 8'hA5, 8'hA5, 1'b0);
    finish_pair(1, rise);
    check("rfd_rise_b3", 32'(rise - last_k), 32'd33);

    // Reset mid-frame, then every accumulator must read back 0.
    start_pair(0, 4'd9, 8'h77, 8'h77, 1'b1);
    while (cyc < last_k + 5) @(negedge clock);
    @(posedge clock); #3;
    reset_ = 1'b0;
    #1;
    check("midrst_out", 32'(out1), 32'd1);
    check("midrst_rfd", 32'(if1.rfd), 32'd1);
    check("midrst_sum", 32'(sum1), 32'd0);
    drive(0, 1'b1, 4'h0, 8'h00);
    @(negedge clock);
    reset_ = 1'b1;
    for (int a = 0; a < 16; a++) send(0, 4'(a), 8'h00, 8'h00);

    repeat (5) @(negedge clock);
    check("queue_empty", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
